phase_step_ctrl: RTL and testbench

//  Sequences the phase accumulator that drives the even/odd clock-select decoder.

---
 rtl/phase_ctrl_pkg.sv | 22 ++
 rtl/phase_accum.sv | 49 ++++
 rtl/phase_step_ctrl.sv | 131 +++++++++++++
 tb/tb_phase_step_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/phase_ctrl_pkg.sv
// ============================================================================
// Module  : phase_ctrl_pkg
// Brief   : Shared state encodings and default widths for the phase stepper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package phase_ctrl_pkg;

    localparam int DEF_ACC_W = 8;
    localparam int DEF_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_PEND  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/phase_accum.sv
// ============================================================================
// Module  : phase_accum
// Brief   : Registered modulo-2^WIDTH adder with carry, load, hold and clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module phase_accum #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             add_en,
    input  logic [WIDTH-1:0] step,
    output logic [OUT_W-1:0] acc_top,
    output logic             carry,
    output logic             carry_nxt
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign sum       = {1'b0, acc} + {1'b0, step};
    assign carry_nxt = sum[WIDTH];
    assign acc_top   = acc[WIDTH-1 -: OUT_W];

    // carry is a one-cycle flag tied to the update that produced it
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (load) begin
            acc   <= load_val;
            carry <= 1'b0;
        end else if (add_en) begin
            acc   <= sum[WIDTH-1:0];
            carry <= sum[WIDTH];
        end else begin
            carry <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/phase_step_ctrl.sv
// ============================================================================
// Module  : phase_step_ctrl
// Brief   : Phase accumulator sequencer with wrap-deferred step reconfiguration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module phase_step_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic [ACC_W-1:0] cfg_phase,
    input  logic             enable,
    input  logic             stop,
    output logic [SEL_W-1:0] acc_sel,
    output logic             sel_vld,
    output logic             wrap,
    output logic             cfg_pend
);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] step_r;
    logic [ACC_W-1:0] shadow;
    logic [SEL_W-1:0] acc_top;
    logic             carry_nxt;
    logic             transfer;
    logic             acc_clear, acc_load, acc_add;
    logic             step_load, shadow_load, shadow_apply;

    assign cfg_ready = (state == ST_IDLE) || (state == ST_RUN);
    assign sel_vld   = (state == ST_RUN) || (state == ST_PEND);
    assign cfg_pend  = (state == ST_PEND);
    assign transfer  = cfg_valid & cfg_ready & ~stop;
    // ARMED holds the loaded offset, but the decoder must see 0 until running
    assign acc_sel   = sel_vld ? acc_top : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_clear    = 1'b0;
        acc_load     = 1'b0;
        acc_add      = 1'b0;
        step_load    = 1'b0;
        shadow_load  = 1'b0;
        shadow_apply = 1'b0;
        if (stop) begin
            state_nxt = ST_IDLE;
            acc_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        acc_load  = 1'b1;
                        step_load = 1'b1;
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (enable) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_add = enable;
                    if (transfer) begin
                        shadow_load = 1'b1;
                        state_nxt   = ST_PEND;
                    end
                end
                ST_PEND: begin
                    acc_add = enable;
                    // a zero step never carries, so swap on the next enabled edge
                    if (enable && (carry_nxt || step_r == '0)) begin
                        shadow_apply = 1'b1;
                        state_nxt    = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            step_r <= '0;
            shadow <= '0;
        end else begin
            if (step_load) begin
                step_r <= cfg_step;
            end else if (shadow_apply) begin
                step_r <= shadow;
            end
            if (shadow_load) begin
                shadow <= cfg_step;
            end
        end
    end

    phase_accum #(
        .WIDTH (ACC_W),
        .OUT_W (SEL_W)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (acc_clear),
        .load      (acc_load),
        .load_val  (cfg_phase),
        .add_en    (acc_add),
        .step      (step_r),
        .acc_top   (acc_top),
        .carry     (wrap),
        .carry_nxt (carry_nxt)
    );

endmodule

`default_nettype wire

// File: tb/tb_phase_step_ctrl.sv
// ============================================================================
// Module  : tb_phase_step_ctrl
// Brief   : Scoreboard bench for phase_step_ctrl at ACC_W=8, SEL_W=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_phase_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_step;
    logic [7:0] cfg_phase;
    logic       enable;
    logic       stop;
    logic [3:0] acc_sel;
    logic       sel_vld;
    logic       wrap;
    logic       cfg_pend;

    typedef struct packed {
        logic [3:0] sel;
        logic       vld;
        logic       wrp;
        logic       pend;
        logic       rdy;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference state
    logic [1:0] m_state;
    logic [7:0] m_acc, m_step, m_shadow;
    logic       m_wrap;

    always #5 clk = ~clk;

    phase_step_ctrl #(.ACC_W(8), .SEL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_step  (cfg_step),
        .cfg_phase (cfg_phase),
        .enable    (enable),
        .stop      (stop),
        .acc_sel   (acc_sel),
        .sel_vld   (sel_vld),
        .wrap      (wrap),
        .cfg_pend  (cfg_pend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (m_state == 2'd0) || (m_state == 2'd2);
    endfunction

    task automatic model_reset();
        m_state = 2'd0; m_acc = 8'h00; m_step = 8'h00; m_shadow = 8'h00; m_wrap = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] st, input logic [7:0] ph,
                              input logic en, input logic sp, input logic rn);
        logic       xfer;
        logic [8:0] sum;
        xfer   = v & m_ready() & ~sp;
        sum    = {1'b0, m_acc} + {1'b0, m_step};
        m_wrap = 1'b0;
        if (!rn || sp) begin
            model_reset();
        end else begin
            case (m_state)
                2'd0: if (xfer) begin m_step = st; m_acc = ph; m_state = 2'd1; end
                2'd1: if (en) m_state = 2'd2;
                2'd2: begin
                    if (en) begin m_acc = sum[7:0]; m_wrap = sum[8]; end
                    if (xfer) begin m_shadow = st; m_state = 2'd3; end
                end
                default: if (en) begin
                    m_acc  = sum[7:0];
                    m_wrap = sum[8];
                    if (sum[8] || m_step == 8'h00) begin m_step = m_shadow; m_state = 2'd2; end
                end
            endcase
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] st, input logic [7:0] ph,
                       input logic en, input logic sp, input logic rn);
        exp_t e;
        logic run;
        cfg_valid = v; cfg_step = st; cfg_phase = ph; enable = en; stop = sp; rst_n = rn;
        check("cfg_ready_pre", {31'd0, cfg_ready}, {31'd0, m_ready()});
        model_edge(v, st, ph, en, sp, rn);
        run    = (m_state == 2'd2) || (m_state == 2'd3);
        e.sel  = run ? m_acc[7:4] : 4'h0;
        e.vld  = run;
        e.wrp  = m_wrap;
        e.pend = (m_state == 2'd3);
        e.rdy  = m_ready();
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check("acc_sel",   {28'd0, acc_sel},   {28'd0, e.sel});
        check("sel_vld",   {31'd0, sel_vld},   {31'd0, e.vld});
        check("wrap",      {31'd0, wrap},      {31'd0, e.wrp});
        check("cfg_pend",  {31'd0, cfg_pend},  {31'd0, e.pend});
        check("cfg_ready", {31'd0, cfg_ready}, {31'd0, e.rdy});
    endtask

    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    logic [3:0] seq1 [8];

    initial begin
        seq1 = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h0};
        cfg_valid = 1'b0; cfg_step = '0; cfg_phase = '0; enable = 1'b0; stop = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_sel_vld",   {31'd0, sel_vld},   32'd0);
        check("rst_acc_sel",   {28'd0, acc_sel},   32'd0);
        check("rst_wrap",      {31'd0, wrap},      32'd0);

        // 1: step 0x20 from phase 0
        cyc(1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t1_first_sel", {28'd0, acc_sel}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
            check("t1_seq",  {28'd0, acc_sel}, {28'd0, seq1[i % 8]});
            check("t1_wrap", {31'd0, wrap},    {31'd0, (i % 8) == 7});
        end

        // 2: deferred step change offered at acc=0x60
        run_en(3);
        cyc(1'b1, 8'h40, 8'h00, 1'b1, 1'b0, 1'b1);
        check("t2_pend", {31'd0, cfg_pend}, 32'd1);
        check("t2_sel",  {28'd0, acc_sel},  32'h8);
        run_en(4);
        check("t2_wrap_pend_clr", {30'd0, wrap, cfg_pend}, 32'b10);
        run_en(4);
        check("t2_new_step_wrap", {28'd0, acc_sel}, 32'h0);

        // 3: offset near top wraps on first update
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h10, 8'hF8, 1'b0, 1'b0, 1'b1);
        check("t3_armed_sel", {30'd0, sel_vld, cfg_ready}, 32'b00);
        run_en(2);
        check("t3_wrap", {31'd0, wrap}, 32'd1);

        // 4: enable gaps at step 0x30
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h30, 8'h00, 1'b0, 1'b0, 1'b1);
        run_en(1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 8'h00, (i % 4 == 0) || (i % 4 == 3), 1'b0, 1'b1);

        // 5: stop beats a config offered in PEND
        cyc(1'b1, 8'h50, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 8'h70, 8'h33, 1'b1, 1'b1, 1'b1);
        check("t5_idle", {28'd0, sel_vld, cfg_pend, cfg_ready, wrap}, 32'b0010);

        // zero step in PEND applies shadow without wrap
        cyc(1'b1, 8'h00, 8'h40, 1'b0, 1'b0, 1'b1);
        run_en(3);
        cyc(1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        run_en(4);

        // 6: reset mid-run at acc=0xA0
        cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1);
        run_en(6);
        check("t6_at_a0", {28'd0, acc_sel}, 32'hA);
        cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        check("t6_reset", {29'd0, sel_vld, cfg_ready, wrap}, 32'b010);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(3) == 0), 8'($urandom_range(255)) & 8'hF0, 8'($urandom_range(255)),
                ($urandom_range(3) != 0), ($urandom_range(40) == 0), ($urandom_range(80) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
